i2s_rx_controller: RTL



---
 rtl/i2s_rx_controller_if.sv | 23 ++
 rtl/i2s_rx_controller.sv | 127 ++++++++++++
 2 files changed

// File: rtl/i2s_rx_controller_if.sv
// Stereo frame handshake from the I2S receiver (master) to the effects pipeline (slave).
interface i2s_rx_controller_if #(
    parameter int DATA_W = 24
);
    logic              frame_valid;
    logic              frame_ready;
    logic [DATA_W-1:0] left_data;
    logic [DATA_W-1:0] right_data;

    modport master (
        output frame_valid,
        output left_data,
        output right_data,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  left_data,
        input  right_data,
        output frame_ready
    );
endinterface

// File: rtl/i2s_rx_controller.sv
// I2S master receiver: derives sclk/lrclk from mclk, captures stereo ADC frames, valid/ready output.
// Optional I2S_OVERRUN_CNT_EN adds a saturating dropped-frame counter ovr_count.
module i2s_rx_controller #(
    parameter int MCLK_PER_SCLK  = 4,
    parameter int SCLK_PER_FRAME = 64,
    parameter int DATA_W         = 24
) (
    input  logic mclk,
    input  logic rst,
    input  logic enable,
    input  logic sdin,
    input  logic ovr_clr,
    i2s_rx_controller_if.master frame,
    output logic sclk_out,
    output logic lrclk_out,
    output logic overrun
`ifdef I2S_OVERRUN_CNT_EN
    ,
    output logic [7:0] ovr_count
`endif
);
    localparam int DIV_W = (MCLK_PER_SCLK > 2) ? $clog2(MCLK_PER_SCLK) : 1;
    localparam int BIT_W = $clog2(SCLK_PER_FRAME);

    localparam logic [DIV_W-1:0] RISE_AT  = DIV_W'(MCLK_PER_SCLK / 2 - 1);
    localparam logic [DIV_W-1:0] FALL_AT  = DIV_W'(MCLK_PER_SCLK - 1);
    localparam logic [DIV_W-1:0] DIV_HI   = DIV_W'(MCLK_PER_SCLK / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SCLK_PER_FRAME - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(SCLK_PER_FRAME / 2);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_DW   = BIT_W'(DATA_W);

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

    buf_state_t        state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt, slot;
    logic [DATA_W-1:0] shreg, word, left_hold;
    logic              rise, fall, right_half, capture;
    logic              left_done, frame_done, drop, load, xfer;

    always_comb begin
        rise       = enable && (div_cnt == RISE_AT);
        fall       = enable && (div_cnt == FALL_AT);
        right_half = (bit_cnt >= BIT_HALF);
        slot       = right_half ? (bit_cnt - BIT_HALF) : bit_cnt;
        capture    = rise && (slot >= BIT_ONE) && (slot <= BIT_DW);
        // word is the shift register after this capture, so completion needs no extra cycle
        word       = DATA_W'({shreg, sdin});
        left_done  = capture && !right_half && (slot == BIT_DW);
        frame_done = capture &&  right_half && (slot == BIT_DW);

        div_nxt = '0;
        if (enable && (div_cnt != FALL_AT))
            div_nxt = div_cnt + 1'b1;

        bit_nxt = '0;
        if (enable)
            bit_nxt = !fall ? bit_cnt : ((bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1);
    end

    always_comb begin
        xfer      = (state == BUF_FULL) && frame.frame_ready;
        drop      = frame_done && (state == BUF_FULL) && !frame.frame_ready;
        load      = frame_done && !drop;
        state_nxt = state;
        if (load)
            state_nxt = BUF_FULL;
        else if (xfer)
            state_nxt = BUF_EMPTY;
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state            <= BUF_EMPTY;
            div_cnt          <= '0;
            bit_cnt          <= '0;
            sclk_out         <= 1'b0;
            lrclk_out        <= 1'b0;
            shreg            <= '0;
            left_hold        <= '0;
            frame.left_data  <= '0;
            frame.right_data <= '0;
            overrun          <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            sclk_out  <= (div_nxt >= DIV_HI);
            lrclk_out <= (bit_nxt >= BIT_HALF);

            if (!enable)
                shreg <= '0;
            else if (capture)
                shreg <= word;

            if (!enable)
                left_hold <= '0;
            else if (left_done)
                left_hold <= word;

            if (load) begin
                frame.left_data  <= left_hold;
                frame.right_data <= word;
            end

            if (drop)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

    assign frame.frame_valid = (state == BUF_FULL);

`ifdef I2S_OVERRUN_CNT_EN
    always_ff @(posedge mclk or posedge rst) begin
        if (rst)
            ovr_count <= '0;
        else if (drop)
            ovr_count <= ovr_clr ? 8'd1 : ((ovr_count == 8'hFF) ? 8'hFF : ovr_count + 8'd1);
        else if (ovr_clr)
            ovr_count <= '0;
    end
`endif

endmodule
